// File: rtl/csa_batch_resolver_if.sv
// Purpose : operand-in / result-out handshake bundle for csa_batch_resolver.
// Ports   : in_valid/in_ready/in_data/in_last carry operand beats towards the block;
//           out_valid/out_ready/out_sum/out_count carry the resolved batch result away.
interface csa_batch_resolver_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  // Producer/consumer side: drives operands, accepts results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  // Resolver side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/csa_batch_resolver.sv
// Purpose : folds a batch of unsigned operands into a carry-save pair, then resolves it to binary.
// Latency : result valid ACC_W/CHUNK cycles after the in_last beat is accepted.
// Backpressure: in_ready drops from last-accept until the result handshake; result held until out_ready.
// Ports   : i_clk, i_rst (synchronous, active-high); bus (slave modport) carries the operand
//           stream in and the out_sum/out_count result out.
module csa_batch_resolver #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 40,
  parameter int CHUNK = 8,
  parameter int CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  csa_batch_resolver_if.slave  bus
);

  localparam int N     = ACC_W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_out_count;
  logic [ACC_W-1:0] r_out_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_cin;

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_s_next;
  logic [ACC_W-1:0] w_c_next;
  logic [CHUNK-1:0] w_s_chunk;
  logic [CHUNK-1:0] w_c_chunk;
  logic [CHUNK:0]   w_chunk_add;
  logic             w_accept;
  logic             w_take;

  assign w_accept = bus.in_valid && (r_state == ST_ACCUM);
  assign w_take   = bus.out_ready && (r_state == ST_DONE);

  // 3:2 compression of (S, C, X); the carry vector shifts up one place and
  // its top bit falls off, which is what keeps everything mod 2^ACC_W.
  assign w_x      = {{(ACC_W-WIDTH){1'b0}}, bus.in_data};
  assign w_s_next = r_s ^ r_c ^ w_x;
  assign w_c_next = ((r_s & r_c) | (r_s & w_x) | (r_c & w_x)) << 1;

  // One CHUNK-wide slice of the carry-propagate add per cycle, ripple carry
  // between slices held in r_cin.
  assign w_s_chunk   = r_s[r_idx*CHUNK +: CHUNK];
  assign w_c_chunk   = r_c[r_idx*CHUNK +: CHUNK];
  assign w_chunk_add = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + {{CHUNK{1'b0}}, r_cin};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_ACCUM;
      r_s         <= '0;
      r_c         <= '0;
      r_count     <= '0;
      r_out_count <= '0;
      r_out_sum   <= '0;
      r_idx       <= '0;
      r_cin       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_s     <= w_s_next;
            r_c     <= w_c_next;
            r_count <= r_count + 1'b1;
            if (bus.in_last) begin
              // Count is latched separately so it survives the post-handshake clear.
              r_out_count <= r_count + 1'b1;
              r_idx       <= '0;
              r_cin       <= 1'b0;
              r_state     <= ST_RESOLVE;
            end
          end
        end
        ST_RESOLVE: begin
          r_out_sum[r_idx*CHUNK +: CHUNK] <= w_chunk_add[CHUNK-1:0];
          r_cin <= w_chunk_add[CHUNK];
          r_idx <= r_idx + 1'b1;
          if (r_idx == IDX_W'(N-1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_take) begin
            r_s     <= '0;
            r_c     <= '0;
            r_count <= '0;
            r_state <= ST_ACCUM;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;

endmodule

// File: tb/tb_csa_batch_resolver.sv
module tb_csa_batch_resolver;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csa_batch_resolver_if #(.WIDTH(32), .ACC_W(40), .CNT_W(8)) u_if ();

  csa_batch_resolver #(.WIDTH(32), .ACC_W(40), .CHUNK(8), .CNT_W(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for exactly one rising edge (block is in ACCUM, so it is taken).
  task automatic send(input logic [31:0] d, input logic l);
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    u_if.in_last  = l;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
  endtask

  // out_valid must rise on exactly the 5th edge after the last-accept edge.
  task automatic check_latency(input string tag);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check(tag, 64'(u_if.out_valid), 64'(i == 5));
      check({tag, "_rdy"}, 64'(u_if.in_ready), 64'd0);
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b0;
    check({tag, "_vld_after"}, 64'(u_if.out_valid), 64'd0);
    check({tag, "_rdy_after"}, 64'(u_if.in_ready), 64'd1);
  endtask

  initial begin
    rst            = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_last   = 1'b0;
    u_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(u_if.in_ready), 64'd1);
    check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("rst_out_sum", 64'(u_if.out_sum), 64'd0);
    check("rst_out_count", 64'(u_if.out_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // T1: 10 + 2 + 15
    send(32'd10, 1'b0);
    send(32'd2, 1'b0);
    send(32'd15, 1'b1);
    check_latency("t1_lat");
    check("t1_sum", 64'(u_if.out_sum), 64'd27);
    check("t1_count", 64'(u_if.out_count), 64'd3);
    take("t1");

    // T2: two batches back to back, state must clear between them
    send(32'd123, 1'b0);
    send(32'd234, 1'b0);
    send(32'd345, 1'b1);
    check_latency("t2a_lat");
    check("t2a_sum", 64'(u_if.out_sum), 64'd702);
    check("t2a_count", 64'(u_if.out_count), 64'd3);
    take("t2a");
    send(32'd50, 1'b0);
    send(32'd100, 1'b0);
    send(32'd75, 1'b1);
    check_latency("t2b_lat");
    check("t2b_sum", 64'(u_if.out_sum), 64'd225);
    check("t2b_count", 64'(u_if.out_count), 64'd3);

    // T3: hold result 4 cycles with stray in_valid pulses
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.in_valid = (i % 2 == 0);
      u_if.in_data  = 32'd99;
      u_if.in_last  = 1'b1;
      @(posedge clk);
      #1;
      check("t3_hold_vld", 64'(u_if.out_valid), 64'd1);
      check("t3_hold_sum", 64'(u_if.out_sum), 64'd225);
      check("t3_hold_count", 64'(u_if.out_count), 64'd3);
      check("t3_hold_rdy", 64'(u_if.in_ready), 64'd0);
    end
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    take("t3");
    send(32'd5, 1'b0);
    send(32'd7, 1'b0);
    send(32'd8, 1'b1);
    check_latency("t3_lat");
    check("t3_sum", 64'(u_if.out_sum), 64'd20);
    check("t3_count", 64'(u_if.out_count), 64'd3);
    take("t3b");

    // T4: carry ripples across chunk boundaries, idle gaps between beats
    repeat (3) @(posedge clk);
    send(32'h00FF_FFFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t4_gap_rdy", 64'(u_if.in_ready), 64'd1);
    send(32'd1, 1'b1);
    check_latency("t4_lat");
    check("t4_sum", 64'(u_if.out_sum), 64'h00_0100_0000);
    check("t4_count", 64'(u_if.out_count), 64'd2);
    take("t4");

    // T5: 256 x FFFFFFFF -> 2^40 - 256, count wraps to 0
    for (int i = 0; i < 256; i++) begin
      send(32'hFFFF_FFFF, i == 255);
    end
    check_latency("t5_lat");
    check("t5_sum", 64'(u_if.out_sum), 64'h00FF_FFFF_FF00);
    check("t5_count", 64'(u_if.out_count), 64'd0);
    take("t5");

    // T6: reset in the middle of RESOLVE
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_vld", 64'(u_if.out_valid), 64'd0);
    check("t6_rst_rdy", 64'(u_if.in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("t6_idle_vld", 64'(u_if.out_valid), 64'd0);
    send(32'd20, 1'b0);
    send(32'd30, 1'b0);
    send(32'd25, 1'b1);
    check_latency("t6_lat");
    check("t6_sum", 64'(u_if.out_sum), 64'd75);
    check("t6_count", 64'(u_if.out_count), 64'd3);
    take("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
